// File: rtl/ioctl_upload_server.sv
// Host upload (read) end of the ioctl channel: turns ioctl_rd strobes into variable-latency
// memory reads. Define UPLOAD_CHECKSUM_EN to build the running mod-256 sum on upload_sum.
module ioctl_upload_server #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned SIZE    = 4096,
  parameter logic [7:0]  INDEX   = 8'h01,
  parameter logic [7:0]  FILL    = 8'hFF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  output logic              upload_active,
  output logic              upload_err,
  output logic [7:0]        upload_sum
);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              err_q, err_d;
  logic              active_q;
  logic              sel, in_window, session_start;
  logic              deliver;
  logic [7:0]        deliver_byte;

  assign sel           = ioctl_upload && (ioctl_index == INDEX);
  assign in_window     = {7'd0, ioctl_addr} < SIZE;
  assign session_start = sel && !active_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    addr_d       = addr_q;
    din_d        = din_q;
    err_d        = session_start ? 1'b0 : err_q;
    deliver      = 1'b0;
    deliver_byte = FILL;
    case (state_q)
      StIdle: begin
        if (ioctl_rd && sel) begin
          if (in_window) begin
            state_d = StFetch;
            addr_d  = ioctl_addr[ADDR_W-1:0];
            timer_d = 8'd0;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      StFetch: begin
        timer_d = timer_q + 8'd1;
        // Abort beats a same-cycle mem_valid so a dropped session never delivers.
        if (!sel) begin
          state_d = StIdle;
        end else if (mem_valid) begin
          state_d      = StIdle;
          deliver      = 1'b1;
          deliver_byte = mem_data;
        end else if (timer_q == TimerLast) begin
          state_d = StIdle;
          deliver = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (deliver) din_d = deliver_byte;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      timer_q  <= 8'd0;
      addr_q   <= '0;
      din_q    <= 8'd0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      err_q    <= err_d;
      active_q <= sel;
    end
  end

  assign ioctl_din     = din_q;
  assign ioctl_wait    = (state_q == StFetch);
  assign mem_rd        = (state_q == StFetch);
  assign mem_addr      = addr_q;
  assign upload_active = active_q;
  assign upload_err    = err_q;

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = session_start ? 8'h00 : sum_q;
    if (deliver) sum_d = sum_d + deliver_byte;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum_q <= 8'h00;
    else          sum_q <= sum_d;
  end

  assign upload_sum = sum_q;
`else
  assign upload_sum = 8'h00;
`endif

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Randomised scoreboard bench for ioctl_upload_server; build with the same UPLOAD_CHECKSUM_EN
// setting as the RTL.
module tb_ioctl_upload_server;

  localparam int unsigned Timeout = 255;
  localparam logic [7:0]  Fill    = 8'hFF;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_valid = 1'b0;
  logic        upload_active;
  logic        upload_err;
  logic [7:0]  upload_sum;

  always #5 clk_sys = ~clk_sys;

  ioctl_upload_server dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_valid    (mem_valid),
    .upload_active(upload_active),
    .upload_err   (upload_err),
    .upload_sum   (upload_sum)
  );

  logic [7:0] mem [0:4095];
  assign mem_data = mem[mem_addr[11:0]];

  typedef struct {
    logic [7:0]  din;
    logic        err;
    logic [7:0]  sum;
    logic [15:0] addr;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model state: what the host should see after each transaction.
  logic [7:0]  din_m = 8'h00;
  logic [7:0]  sum_m = 8'h00;
  logic        err_m = 1'b0;
  logic [15:0] addr_m = 16'h0000;
  bit          sel_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic deliver_m(input logic [7:0] b);
    din_m = b;
`ifdef UPLOAD_CHECKSUM_EN
    sum_m = sum_m + b;
`endif
  endtask

  task automatic push(input int cycles);
    exp_t e;
    e.din = din_m; e.err = err_m; e.sum = sum_m; e.addr = addr_m; e.cycles = cycles;
    exp_q.push_back(e);
  endtask

  task automatic set_sel(input bit on, input logic [7:0] idx);
    ioctl_upload = on;
    ioctl_index  = idx;
    if (on && idx == 8'h01 && !sel_m) begin
      err_m = 1'b0;
      sum_m = 8'h00;
    end
    sel_m = on && (idx == 8'h01);
  endtask

  // lat: cycle of mem_rd in which memory answers; lat > Timeout means it never answers.
  task automatic rd_in(input logic [15:0] a, input int lat);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'(a);
    addr_m     = a;
    if (lat <= int'(Timeout)) begin
      deliver_m(mem[a[11:0]]);
      push(lat);
    end else begin
      err_m = 1'b1;
      deliver_m(Fill);
      push(int'(Timeout));
    end
    tick();
    ioctl_rd = 1'b0;
    if (lat >= 2) begin
      ioctl_rd   = 1'b1;  // stray strobe while stalled must be ignored
      ioctl_addr = 25'($urandom);
    end
    if (lat <= int'(Timeout)) begin
      for (int i = 1; i < lat; i++) begin
        tick();
        ioctl_rd = 1'b0;
      end
      mem_valid = 1'b1;
      tick();
      mem_valid = 1'b0;
    end else begin
      for (int i = 0; i < int'(Timeout); i++) begin
        tick();
        ioctl_rd = 1'b0;
      end
    end
  endtask

  task automatic rd_out(input logic [24:0] a);
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    deliver_m(Fill);
    push(0);
    tick();
    ioctl_rd = 1'b0;
  endtask

  task automatic abort_rd(input logic [15:0] a, input int k);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'(a);
    addr_m     = a;
    push(k);
    tick();
    ioctl_rd = 1'b0;
    for (int i = 1; i < k; i++) tick();
    set_sel(1'b0, 8'h01);
    tick();
    tick();
    set_sel(1'b1, 8'h01);
    tick();
  endtask

  task automatic ignored_rd(input logic [7:0] idx);
    set_sel(1'b1, idx);
    tick();
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'($urandom_range(0, 4095));
    tick();
    ioctl_rd = 1'b0;
    chk("ignored_active", upload_active, 1'b0);
    tick();
    chk("ignored_mem_rd", mem_rd, 1'b0);
    set_sel(1'b1, 8'h01);
    tick();
  endtask

  task automatic restart_session();
    set_sel(1'b0, 8'h01);
    tick();
    tick();
    set_sel(1'b1, 8'h01);
    tick();
    tick();
  endtask

  // Monitor: a transaction ends when ioctl_wait falls, or one cycle after an unstalled
  // accepted strobe that never raised ioctl_wait.
  initial begin
    logic prev_wait, prev_req;
    int   wcnt;
    exp_t e;
    prev_wait = 1'b0; prev_req = 1'b0; wcnt = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        prev_wait = 1'b0; prev_req = 1'b0; wcnt = 0;
      end else begin
        if (ioctl_wait) begin
          wcnt++;
        end else if (prev_wait || prev_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_end", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("din", ioctl_din, e.din);
            chk("err", upload_err, e.err);
            chk("sum", upload_sum, e.sum);
            chk("mem_addr", mem_addr, e.addr);
            chk("wait_cycles", wcnt, e.cycles);
            chk("mem_rd_low", mem_rd, 1'b0);
          end
          wcnt = 0;
        end
        prev_wait = ioctl_wait;
        prev_req  = ioctl_rd && ioctl_upload && (ioctl_index == 8'h01) && !ioctl_wait;
      end
    end
  end

  initial begin
    int kind;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

    // Reset with strobes and mem_valid active.
    ioctl_upload = 1'b1; ioctl_index = 8'h01; ioctl_rd = 1'b1; ioctl_addr = 25'h10;
    mem_valid = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_din", ioctl_din, 8'h00);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_active", upload_active, 1'b0);
    chk("rst_err", upload_err, 1'b0);
    chk("rst_sum", upload_sum, 8'h00);
    @(posedge clk_sys);
    #1;
    ioctl_rd = 1'b0; mem_valid = 1'b0; reset_n = 1'b1; sel_m = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_mem_rd", mem_rd, 1'b0);
    end
    chk("active_up", upload_active, 1'b1);

    // Basic fetch, window boundaries.
    mem[12'h010] = 8'hA5;
    rd_in(16'h0010, 4);
    rd_out(25'h1000);
    rd_out(25'h1FFFFFF);
    rd_in(16'h0FFF, 1);

    // Timeout, then answer exactly on the last allowed cycle.
    rd_in(16'h0123, 1000);
    rd_in(16'h0456, int'(Timeout));
    restart_session();
    chk("err_cleared", upload_err, 1'b0);
    chk("sum_cleared", upload_sum, 8'h00);

    abort_rd(16'h0200, 2);
    ignored_rd(8'h02);

    // Checksum wrap.
    restart_session();
    mem[12'h100] = 8'h80; mem[12'h101] = 8'h90; mem[12'h102] = 8'h10;
    rd_in(16'h0100, 1);
    rd_in(16'h0101, 2);
    rd_in(16'h0102, 3);
    tick();
`ifdef UPLOAD_CHECKSUM_EN
    chk("sum_wrap", upload_sum, 8'h20);
`else
    chk("sum_wrap", upload_sum, 8'h00);
`endif

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 5)      rd_in(16'($urandom_range(0, 4095)), int'($urandom_range(1, 6)));
      else if (kind <= 7) rd_out(25'($urandom_range(4096, 32'h1FFFFFF)));
      else if (kind == 8) abort_rd(16'($urandom_range(0, 4095)), int'($urandom_range(1, 4)));
      else                ignored_rd(8'($urandom_range(2, 255)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Asynchronous reset in the middle of a fetch.
    ioctl_rd = 1'b1; ioctl_addr = 25'h0321;
    tick();
    ioctl_rd = 1'b0;
    chk("fetch_started", mem_rd, 1'b1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_mem_rd", mem_rd, 1'b0);
    chk("async_wait", ioctl_wait, 1'b0);
    chk("async_mem_addr", mem_addr, 16'h0);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    din_m = 8'h00; sum_m = 8'h00; err_m = 1'b0; addr_m = 16'h0;
    tick();
    chk("post_async_din", ioctl_din, 8'h00);
    rd_in(16'($urandom_range(0, 4095)), 3);
    rd_out(25'h1234);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    tick();
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
